// File: rtl/mttkrp_pkg.sv
// mttkrp_pkg: shared constants, types and helpers for the factor-matrix fetch path
package mttkrp_pkg;
  localparam int NUM_CU = 4;
  localparam int TENSOR_DIM = 3;
  localparam int ADDR_W = 16;
  localparam int MAX_OUT = 8;
  localparam int IDW = $clog2(NUM_CU) + 1;
  localparam logic [IDW-1:0] NO_ID = IDW'(NUM_CU);
  localparam int ONEHOT_W = 64;
  typedef logic [TENSOR_DIM-2:0][ADDR_W-1:0] factor_addr_t;
  function automatic logic [ONEHOT_W-1:0] onehot_id(input int unsigned id, input int unsigned n);
    return (id < n) ? ONEHOT_W'(1) << id : '0;
  endfunction
endpackage

// File: rtl/fetch_id_fifo.sv
// fetch_id_fifo: in-order compute-ID tracker for requests awaiting a memory response
module fetch_id_fifo #(
  parameter int W = 3,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/factor_fetch_arbiter.sv
// factor_fetch_arbiter: round-robin sharing of the factor-matrix read port with in-order response steering.
// Optional per-unit grant / stall counters when FACTOR_FETCH_PERF_COUNTERS_EN is defined.
module factor_fetch_arbiter
  import mttkrp_pkg::*;
#(
  parameter int NUM_COMPUTE_UNITS = NUM_CU,
  parameter int TENSOR_DIMENSIONS = TENSOR_DIM,
  parameter int MODE_TENSOR_ADDR_WIDTH = ADDR_W,
  parameter int MAX_OUTSTANDING = MAX_OUT,
  localparam int IW = $clog2(NUM_COMPUTE_UNITS) + 1,
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_COMPUTE_UNITS-1:0] cu_req_valid,
  input  logic [NUM_COMPUTE_UNITS-1:0][TENSOR_DIMENSIONS-2:0][MODE_TENSOR_ADDR_WIDTH-1:0] cu_req_addr,
  output logic [NUM_COMPUTE_UNITS-1:0] cu_req_ready,
  output logic mem_req_valid,
  output logic [TENSOR_DIMENSIONS-2:0][MODE_TENSOR_ADDR_WIDTH-1:0] mem_req_addr,
  output logic [IW-1:0] mem_req_id,
  input  logic mem_req_ready,
  input  logic mem_rsp_valid,
  output logic [NUM_COMPUTE_UNITS-1:0] rsp_en,
  output logic [IW-1:0] rsp_compute_id,
  output logic [OW-1:0] outstanding,
  output logic idle,
  output logic rsp_underflow
`ifdef FACTOR_FETCH_PERF_COUNTERS_EN
  ,
  output logic [NUM_COMPUTE_UNITS-1:0][31:0] perf_grant_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int PW = NUM_COMPUTE_UNITS > 1 ? $clog2(NUM_COMPUTE_UNITS) : 1;
  localparam logic [IW-1:0] NONE = IW'(NUM_COMPUTE_UNITS);
  logic [PW-1:0] rr_ptr, winner;
  logic found, slot_free, credit, grant, accept, fifo_pop, fifo_empty, fifo_full;
  logic [IW-1:0] fifo_head;
  int idx;
  assign slot_free = !mem_req_valid || mem_req_ready;
  assign credit = int'(outstanding) + int'(mem_req_valid) < MAX_OUTSTANDING;
  // scan downward so the unit closest to rr_ptr is the last (winning) assignment
  always_comb begin
    found = 1'b0;
    winner = rr_ptr;
    idx = 0;
    for (int i = NUM_COMPUTE_UNITS - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      idx = idx >= NUM_COMPUTE_UNITS ? idx - NUM_COMPUTE_UNITS : idx;
      if (cu_req_valid[idx]) begin
        found = 1'b1;
        winner = PW'(idx);
      end
    end
  end
  assign grant = rst && slot_free && credit && found;
  assign cu_req_ready = grant ? NUM_COMPUTE_UNITS'(onehot_id(int'(winner), NUM_COMPUTE_UNITS)) : '0;
  assign accept = mem_req_valid && mem_req_ready;
  assign fifo_pop = rst && mem_rsp_valid && !fifo_empty;
  assign rsp_compute_id = fifo_pop ? fifo_head : NONE;
  assign rsp_en = fifo_pop ? NUM_COMPUTE_UNITS'(onehot_id(int'(fifo_head), NUM_COMPUTE_UNITS)) : '0;
  assign idle = rst && !(|cu_req_valid) && !mem_req_valid && outstanding == '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req_valid <= 1'b0;
      mem_req_addr <= '0;
      mem_req_id <= NONE;
      rr_ptr <= '0;
      outstanding <= '0;
      rsp_underflow <= 1'b0;
    end else begin
      if (grant) begin
        mem_req_valid <= 1'b1;
        mem_req_addr <= cu_req_addr[winner];
        mem_req_id <= IW'(winner);
        rr_ptr <= int'(winner) == NUM_COMPUTE_UNITS - 1 ? '0 : winner + 1'b1;
      end else if (accept) mem_req_valid <= 1'b0;
      outstanding <= outstanding + OW'(accept) - OW'(fifo_pop);
      if (mem_rsp_valid && fifo_empty) rsp_underflow <= 1'b1;
    end
  end
  fetch_id_fifo #(.W(IW), .DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk(clk),
    .flush(!rst),
    .push(accept),
    .push_data(mem_req_id),
    .pop(fifo_pop),
    .head(fifo_head),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  // the credit rule keeps the ID FIFO from ever overflowing
  assert property (@(posedge clk) disable iff (!rst) !(accept && fifo_full))
    else $error("factor_fetch_arbiter: ID FIFO push while full");
`ifdef FACTOR_FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_grant_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_COMPUTE_UNITS; i++)
        if (cu_req_ready[i] && perf_grant_cnt[i] != '1) perf_grant_cnt[i] <= perf_grant_cnt[i] + 32'd1;
      if (|cu_req_valid && !grant && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
